// File: rtl/m31_pkg.sv
// Mersenne-31 field types and reduction helpers shared by the S-box layer and its multipliers.
// All results are canonical in [0, P_M31-1]; inputs may carry the redundant encoding 0x7FFFFFFF.
package m31_pkg;

    typedef logic [30:0] m31_t;

    localparam m31_t P_M31 = 31'h7FFF_FFFF;

    function automatic m31_t m31_add(input m31_t a, input m31_t b);
        logic [31:0] sum_s;
        logic [31:0] fold_s;
        m31_t        res_s;
        sum_s  = {1'b0, a} + {1'b0, b};
        // 2^31 == 1 mod P, so bit 31 folds back in as +1
        fold_s = {1'b0, sum_s[30:0]} + {31'd0, sum_s[31]};
        if (fold_s[30:0] == P_M31) begin
            res_s = 31'd0;
        end else begin
            res_s = fold_s[30:0];
        end
        return res_s;
    endfunction

    function automatic m31_t m31_mul_red(input m31_t a, input m31_t b);
        logic [61:0] prod_s;
        logic [31:0] fold1_s;
        logic [31:0] fold2_s;
        m31_t        res_s;
        prod_s  = {31'd0, a} * {31'd0, b};
        fold1_s = {1'b0, prod_s[30:0]} + {1'b0, prod_s[61:31]};
        fold2_s = {1'b0, fold1_s[30:0]} + {31'd0, fold1_s[31]};
        if (fold2_s[30:0] == P_M31) begin
            res_s = 31'd0;
        end else begin
            res_s = fold2_s[30:0];
        end
        return res_s;
    endfunction

endpackage

// File: rtl/m31_mul.sv
// Combinational 31x31 multiplier modulo the Mersenne prime 2^31-1.
module m31_mul
    import m31_pkg::*;
(
    input  logic [30:0] a,
    input  logic [30:0] b,
    output logic [30:0] p
);

    assign p = m31_mul_red(a, b);

endmodule

// File: rtl/m31_sbox_layer.sv
// Three-stage x^5 S-box layer over WIDTH M31 lanes with valid/ready flow control.
// Full rounds apply the S-box to every lane; partial rounds only to lane 0.
module m31_sbox_layer #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0][30:0] in_state,
    input  logic [WIDTH-1:0][30:0] in_rc,
    input  logic                   in_full,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0][30:0] out_state
);
    import m31_pkg::*;

    logic               s1_v_r;
    logic               s2_v_r;
    logic               s3_v_r;
    logic               s1_full_r;
    logic               s2_full_r;
    m31_t [WIDTH-1:0]   s1_a_r;
    m31_t [WIDTH-1:0]   s1_sq_r;
    m31_t [WIDTH-1:0]   s2_a_r;
    m31_t [WIDTH-1:0]   s2_q4_r;

    logic               s1_ready_s;
    logic               s2_ready_s;
    logic               s3_ready_s;
    m31_t [WIDTH-1:0]   rc_sel_s;
    m31_t [WIDTH-1:0]   a_s;
    m31_t [WIDTH-1:0]   sq_s;
    m31_t [WIDTH-1:0]   q4_s;
    m31_t [WIDTH-1:0]   a5_s;
    m31_t [WIDTH-1:0]   res_s;

    // A slot may load when it is empty or its current occupant leaves this cycle.
    assign s3_ready_s = !s3_v_r || out_ready;
    assign s2_ready_s = !s2_v_r || s3_ready_s;
    assign s1_ready_s = !s1_v_r || s2_ready_s;
    assign in_ready   = s1_ready_s;
    assign out_valid  = s3_v_r;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        localparam logic LANE0 = (g == 32'sd0);

        // Pass-through lanes still go through the adder with rc=0 so 0x7FFFFFFF canonicalises to 0.
        assign rc_sel_s[g] = (in_full || LANE0) ? in_rc[g] : 31'd0;
        assign a_s[g]      = m31_add(in_state[g], rc_sel_s[g]);

        m31_mul u_sq (.a(a_s[g]),     .b(a_s[g]),     .p(sq_s[g]));
        m31_mul u_q4 (.a(s1_sq_r[g]), .b(s1_sq_r[g]), .p(q4_s[g]));
        m31_mul u_q5 (.a(s2_q4_r[g]), .b(s2_a_r[g]),  .p(a5_s[g]));

        assign res_s[g] = (s2_full_r || LANE0) ? a5_s[g] : s2_a_r[g];
    end

    // Pipeline registers; data only loads with a real transfer so stalled or idle outputs stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_r    <= 1'b0;
            s2_v_r    <= 1'b0;
            s3_v_r    <= 1'b0;
            s1_full_r <= 1'b0;
            s2_full_r <= 1'b0;
            s1_a_r    <= '0;
            s1_sq_r   <= '0;
            s2_a_r    <= '0;
            s2_q4_r   <= '0;
            out_state <= '0;
        end else begin
            if (s1_ready_s) begin
                s1_v_r <= in_valid;
            end
            if (s2_ready_s) begin
                s2_v_r <= s1_v_r;
            end
            if (s3_ready_s) begin
                s3_v_r <= s2_v_r;
            end
            if (in_valid && s1_ready_s) begin
                s1_a_r    <= a_s;
                s1_sq_r   <= sq_s;
                s1_full_r <= in_full;
            end
            if (s1_v_r && s2_ready_s) begin
                s2_a_r    <= s1_a_r;
                s2_q4_r   <= q4_s;
                s2_full_r <= s1_full_r;
            end
            if (s2_v_r && s3_ready_s) begin
                out_state <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_m31_sbox_layer.sv
// Directed and scoreboarded checks for m31_sbox_layer at WIDTH=4.
module tb_m31_sbox_layer;

    localparam int W = 4;
    localparam logic [30:0] P = 31'h7FFF_FFFF;
    typedef logic [W-1:0][30:0] vec_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_ready;
    vec_t in_state;
    vec_t in_rc;
    logic in_full;
    logic out_valid;
    logic out_ready;
    vec_t out_state;

    int n_asrt = 0;
    int n_fail = 0;

    m31_sbox_layer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_rc(in_rc), .in_full(in_full),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30:0] ref_sbox(input logic [30:0] s, input logic [30:0] rc);
        longint unsigned a;
        longint unsigned r;
        a = (longint'(s) + longint'(rc)) % longint'(P);
        r = a;
        for (int k = 0; k < 4; k++) r = (r * a) % longint'(P);
        return r[30:0];
    endfunction

    function automatic vec_t ref_vec(input vec_t s, input vec_t rc, input logic full);
        vec_t v;
        for (int i = 0; i < W; i++) begin
            if (full || i == 0) v[i] = ref_sbox(s[i], rc[i]);
            else                v[i] = ref_sbox(s[i], 31'd0) == 31'd0 ? 31'd0 : 31'(longint'(s[i]) % longint'(P));
        end
        return v;
    endfunction

    function automatic logic [30:0] rnd_lane();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 7) == 0) return P;
        return r[30:0];
    endfunction

    // One isolated state with out_ready high: output must appear exactly after the third edge.
    task automatic one_shot(input string tag, input vec_t st, input vec_t rc, input logic full, input vec_t exp);
        in_state = st; in_rc = rc; in_full = full; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 128'(out_valid), 128'(1'b0));
        tick();
        check({tag, "_lat2"}, 128'(out_valid), 128'(1'b0));
        tick();
        check({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, "_data"}, 128'(out_state), 128'(exp));
        tick();
        check({tag, "_drained"}, 128'(out_valid), 128'(1'b0));
    endtask

    // Cycle-stepped stream with scoreboard; rnd selects random stalls/data, else out_ready low in cycles 2-6.
    task automatic run_stream(input string tag, input int n, input logic rnd);
        vec_t q[$];
        vec_t st, rc, prev_out;
        logic full, prev_stall, saw_stall;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; saw_stall = 1'b0; prev_out = '0;
        for (int i = 0; i < W; i++) begin
            st[i] = rnd ? rnd_lane() : 31'(i + 1);
            rc[i] = rnd ? rnd_lane() : 31'd0;
        end
        full = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (got < n && cyc < 30 * n + 50) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 2 && cyc <= 6);
            in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 4) != 0) : 1'b1);
            in_state = st; in_rc = rc; in_full = full;
            #1;
            if (prev_stall) check({tag, "_hold"}, 128'({out_valid, out_state}), 128'({1'b1, prev_out}));
            if (!in_ready) begin
                check({tag, "_buffered"}, 128'(q.size()), 128'(3));
                saw_stall = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check({tag, "_spurious"}, 128'(1'b1), 128'(1'b0));
                else check({tag, "_data"}, 128'(out_state), 128'(q.pop_front()));
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_vec(st, rc, full));
                sent++;
                for (int i = 0; i < W; i++) begin
                    st[i] = rnd ? rnd_lane() : 31'(sent * W + i + 1);
                    rc[i] = rnd ? rnd_lane() : 31'd0;
                end
                full = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out_state;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 128'(got), 128'(n));
        check({tag, "_leftover"}, 128'(q.size()), 128'(0));
        if (!rnd) check({tag, "_stall_seen"}, 128'(saw_stall), 128'(1'b1));
        tick();
        check({tag, "_idle"}, 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_rc = '0; in_full = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_state", 128'(out_state), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("post_rst_out_valid", 128'(out_valid), 128'(1'b0));
        tick();

        one_shot("small", {31'd3, 31'd2, 31'd3, 31'd2}, '0, 1'b1,
                 {31'd243, 31'd32, 31'd243, 31'd32});
        one_shot("edge", {P, P, 31'h7FFF_FFFE, 31'h7FFF_FFFE}, {P, 31'd0, 31'd1, 31'd0}, 1'b1,
                 {31'd0, 31'd0, 31'd0, 31'h7FFF_FFFE});
        one_shot("mixed", {31'd100, 31'h7FFF_FFFD, 31'd0, 31'd10}, {31'd0, 31'd5, 31'd0, 31'd7}, 1'b1,
                 {31'd1410065412, 31'd243, 31'd0, 31'd1419857});
        one_shot("partial", {31'd4, 31'd3, 31'd2, 31'd1}, {31'd5, 31'd5, 31'd5, 31'd5}, 1'b0,
                 {31'd4, 31'd3, 31'd2, 31'd7776});

        run_stream("bp", 8, 1'b0);

        // Two states in flight, then a one-cycle reset.
        in_state = {31'd9, 31'd9, 31'd9, 31'd9}; in_rc = '0; in_full = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        check("midrst_out_state", 128'(out_state), 128'(0));
        tick();
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(1'b1));
        one_shot("after_rst", {31'd2, 31'd2, 31'd2, 31'd2}, {31'd1, 31'd1, 31'd1, 31'd1}, 1'b1,
                 {31'd243, 31'd243, 31'd243, 31'd243});

        run_stream("rand", 300, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
